// File: rtl/dtcm_arbiter.sv
// Two-master arbiter and sequencer in front of the single-ported DTCM.
// m0 has fixed priority; m1 is guaranteed a grant after MAX_HOLD m0 wins.
module dtcm_arbiter #(
  parameter int          IO_MAP_WIDTH = 32,
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_HOLD     = 4,
  parameter int          TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_rw,
  input  logic [31:0]             m0_addr,
  input  logic [IO_MAP_WIDTH-1:0] m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [IO_MAP_WIDTH-1:0] m0_rdata,
  output logic                    m0_err,
  input  logic                    m1_req,
  input  logic                    m1_rw,
  input  logic [31:0]             m1_addr,
  input  logic [IO_MAP_WIDTH-1:0] m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [IO_MAP_WIDTH-1:0] m1_rdata,
  output logic                    m1_err,
  output logic [ADDR_WIDTH-1:0]   dtcm_addr,
  output logic [IO_MAP_WIDTH-1:0] dtcm_wdata,
  output logic                    dtcm_rw,
  input  logic [IO_MAP_WIDTH-1:0] dtcm_rdata,
  input  logic                    dtcm_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int WCW = $clog2(MAX_HOLD + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] HOLD    = WCW'(MAX_HOLD);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

  state_t                  state;
  logic [WCW-1:0]          win_cnt;
  logic [TCW-1:0]          to_cnt;
  logic                    owner;
  logic                    rw_q;

  logic                    idle;
  logic                    m1_win;
  logic                    any_gnt;
  logic                    sel_rw;
  logic [31:0]             sel_addr;
  logic [IO_MAP_WIDTH-1:0] sel_wdata;
  logic [32:0]             rel;
  logic                    addr_ok;
  logic [ADDR_WIDTH-1:0]   offset;

  logic                    fin;
  logic                    fin_err;
  logic                    fin_m1;
  logic [IO_MAP_WIDTH-1:0] fin_data;

  assign idle    = (state == IDLE);
  assign m1_win  = m1_req && (!m0_req || win_cnt == HOLD);
  assign m1_gnt  = rst && idle && m1_win;
  assign m0_gnt  = rst && idle && m0_req && !m1_win;
  assign any_gnt = m0_gnt || m1_gnt;

  assign sel_rw    = m1_win ? m1_rw    : m0_rw;
  assign sel_addr  = m1_win ? m1_addr  : m0_addr;
  assign sel_wdata = m1_win ? m1_wdata : m0_wdata;

  // rel[32] is the borrow, set when the address lies below the window
  assign rel     = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
  assign addr_ok = (sel_addr[1:0] == 2'b00) && !rel[32]
                && ((rel[31:0] >> ADDR_WIDTH) == 32'd0);
  assign offset  = rel[ADDR_WIDTH-1:0];

  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_m1   = owner;
    fin_data = '0;
    unique case (state)
      IDLE: begin
        if (any_gnt && !addr_ok) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          fin_m1  = m1_win;
        end
      end
      WAIT: begin
        if (dtcm_ready) begin
          fin      = 1'b1;
          fin_data = rw_q ? '0 : dtcm_rdata;
        end else if (to_cnt == TO_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      win_cnt    <= '0;
      to_cnt     <= '0;
      owner      <= 1'b0;
      rw_q       <= 1'b0;
      m0_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_rvalid  <= 1'b0;
      m1_rdata   <= '0;
      m1_err     <= 1'b0;
      dtcm_addr  <= '0;
      dtcm_wdata <= '0;
      dtcm_rw    <= 1'b0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (fin) begin
        if (fin_m1) begin
          m1_rvalid <= 1'b1;
          m1_rdata  <= fin_data;
          m1_err    <= fin_err;
        end else begin
          m0_rvalid <= 1'b1;
          m0_rdata  <= fin_data;
          m0_err    <= fin_err;
        end
      end
      unique case (state)
        IDLE: begin
          if (any_gnt) begin
            owner <= m1_win;
            rw_q  <= sel_rw;
            if (m1_win || !m1_req) begin
              win_cnt <= '0;
            end else if (win_cnt != HOLD) begin
              win_cnt <= win_cnt + 1'b1;
            end
            if (addr_ok) begin
              dtcm_addr  <= offset;
              dtcm_wdata <= sel_wdata;
              dtcm_rw    <= sel_rw;
              state      <= ISSUE;
            end else begin
              state <= RESP;
            end
          end
        end
        ISSUE: begin
          dtcm_rw <= 1'b0;
          to_cnt  <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (fin) begin
            state <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Bench for dtcm_arbiter: transaction-level reference model plus
// directed scenarios and randomized two-master traffic.
module tb_dtcm_arbiter;

  localparam int          W    = 32;
  localparam int          AW   = 12;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXH = 4;
  localparam int          TO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req_v = '0;
  logic [1:0]    rw_v = '0;
  logic [31:0]   addr_v [2];
  logic [31:0]   wd_v [2];

  logic          m0_req, m0_rw, m0_gnt, m0_rvalid, m0_err;
  logic          m1_req, m1_rw, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]   m0_addr, m1_addr;
  logic [W-1:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [AW-1:0] dtcm_addr;
  logic [W-1:0]  dtcm_wdata, dtcm_rdata;
  logic          dtcm_rw;
  logic          dtcm_ready;

  assign m0_req   = req_v[0];
  assign m0_rw    = rw_v[0];
  assign m0_addr  = addr_v[0];
  assign m0_wdata = wd_v[0];
  assign m1_req   = req_v[1];
  assign m1_rw    = rw_v[1];
  assign m1_addr  = addr_v[1];
  assign m1_wdata = wd_v[1];

  dtcm_arbiter #(
    .IO_MAP_WIDTH(W),
    .ADDR_WIDTH  (AW),
    .BASE_ADDR   (BASE),
    .MAX_HOLD    (MAXH),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m0_rw      (m0_rw),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m0_err     (m0_err),
    .m1_req     (m1_req),
    .m1_rw      (m1_rw),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .m1_err     (m1_err),
    .dtcm_addr  (dtcm_addr),
    .dtcm_wdata (dtcm_wdata),
    .dtcm_rw    (dtcm_rw),
    .dtcm_rdata (dtcm_rdata),
    .dtcm_ready (dtcm_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // simple DTCM: synchronous write, combinational read
  logic [31:0] mem [0:1023];
  always @(posedge clk) if (dtcm_rw) mem[dtcm_addr[11:2]] <= dtcm_wdata;
  assign dtcm_rdata = mem[dtcm_addr[11:2]];

  int rdy_mode = 0;
  initial begin
    dtcm_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       dtcm_ready = 1'b1;
        1:       dtcm_ready = ($urandom_range(0, 9) < 6);
        default: dtcm_ready = 1'b0;
      endcase
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // reference model state: at most one transaction in flight
  logic [31:0] ref_mem [0:1023];
  bit          p_on = 0;
  bit          p_m, p_rw, p_bad, p_err;
  int          p_t, p_due;
  logic [31:0] p_data;
  int          next_free = 0;
  int          streak = 0;
  logic [11:0] exp_addr = '0;
  logic [31:0] exp_wd = '0;
  int          rw_cnt = 0;
  logic [11:0] last_rw_addr = '0;
  bit          gq [$];

  always @(negedge clk) begin : mon
    logic        e0, e1, m1w, r, erw;
    logic [31:0] a, d, off;
    longint      la;
    if (!rst) begin
      chk("rst_ctl", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
                      m0_err, m1_err, dtcm_rw}, 0);
      chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
      chk("rst_dtcm", {dtcm_addr, dtcm_wdata}, 0);
      p_on = 0;
      streak = 0;
      next_free = 0;
      exp_addr = '0;
      exp_wd = '0;
    end else begin
      e0 = p_on && p_due == cyc && !p_m;
      e1 = p_on && p_due == cyc && p_m;
      chk("m0_rvalid", m0_rvalid, e0);
      chk("m1_rvalid", m1_rvalid, e1);
      if (e0) begin
        chk("m0_rdata", m0_rdata, p_data);
        chk("m0_err", m0_err, p_err);
      end
      if (e1) begin
        chk("m1_rdata", m1_rdata, p_data);
        chk("m1_err", m1_err, p_err);
      end
      if (e0 || e1) begin
        p_on = 0;
        next_free = cyc + 1;
      end
      erw = p_on && !p_bad && p_rw && cyc == p_t + 1;
      chk("dtcm_rw", dtcm_rw, erw);
      chk("dtcm_addr", dtcm_addr, exp_addr);
      chk("dtcm_wdata", dtcm_wdata, exp_wd);
      if (dtcm_rw) begin
        rw_cnt++;
        last_rw_addr = dtcm_addr;
      end
      if (p_on && !p_bad && p_due < 0 && cyc >= p_t + 2) begin
        if (dtcm_ready) begin
          p_due = cyc + 1;
          p_err = 0;
        end else if (cyc == p_t + 1 + TO) begin
          p_due = cyc + 1;
          p_err = 1;
          p_data = 0;
        end
      end
      if (!p_on && cyc >= next_free) begin
        m1w = m1_req && (!m0_req || streak == MAXH);
        e0 = m0_req && !m1w;
        e1 = m1w;
        chk("m0_gnt", m0_gnt, e0);
        chk("m1_gnt", m1_gnt, e1);
        if (e0 || e1) begin
          gq.push_back(e1);
          if (e1 || !m1_req) streak = 0;
          else if (streak < MAXH) streak++;
          a = e1 ? m1_addr : m0_addr;
          d = e1 ? m1_wdata : m0_wdata;
          r = e1 ? m1_rw : m0_rw;
          la = longint'(a);
          p_on = 1;
          p_m = e1;
          p_t = cyc;
          p_rw = r;
          p_bad = (la % 4 != 0) || (la < longint'(BASE))
               || (la >= longint'(BASE) + (longint'(1) << AW));
          if (p_bad) begin
            p_due = cyc + 1;
            p_err = 1;
            p_data = 0;
          end else begin
            p_due = -1;
            off = a - BASE;
            exp_addr = off[11:0];
            exp_wd = d;
            if (r) begin
              ref_mem[off[11:2]] = d;
              p_data = 0;
            end else begin
              p_data = ref_mem[off[11:2]];
            end
          end
        end
      end else begin
        chk("gnt_busy", {m0_gnt, m1_gnt}, 0);
      end
    end
  end

  task automatic wait_gnt(input int m, output int t);
    int  n;
    logic g;
    n = 0;
    t = -1;
    while (t < 0 && n < 300) begin
      @(negedge clk);
      n++;
      g = m ? m1_gnt : m0_gnt;
      if (g) t = cyc;
    end
    if (t < 0) chk($sformatf("gnt_wait_m%0d", m), 0, 1);
  endtask

  task automatic txn(input int m, input logic r, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic e, output int lat);
    int   t, n;
    logic v;
    @(posedge clk);
    #1;
    rw_v[m] = r;
    addr_v[m] = a;
    wd_v[m] = d;
    req_v[m] = 1'b1;
    wait_gnt(m, t);
    @(posedge clk);
    #1;
    req_v[m] = 1'b0;
    lat = -1;
    rd = '0;
    e = 1'b0;
    n = 0;
    while (lat < 0 && n < 64) begin
      @(negedge clk);
      n++;
      v = m ? m1_rvalid : m0_rvalid;
      if (v) begin
        lat = cyc - t;
        rd = m ? m1_rdata : m0_rdata;
        e = m ? m1_err : m0_err;
      end
    end
    if (lat < 0) chk("rvalid_wait", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (p_on && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (p_on) chk("drain", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int m, input int k);
    rw_v[m] = (k % 2 == 0);
    addr_v[m] = 32'h400 + 32'(m) * 32'h100 + 32'(k / 2) * 4;
    wd_v[m] = (32'(m + 1) << 24) | 32'(k);
  endtask

  task automatic stream(input int m);
    int   k, n;
    logic g;
    k = 0;
    n = 0;
    set_fields(m, k);
    req_v[m] = 1'b1;
    while (gq.size() < 20 && n < 400) begin
      @(negedge clk);
      n++;
      g = m ? m1_gnt : m0_gnt;
      if (g) begin
        @(posedge clk);
        #1;
        k++;
        set_fields(m, k);
      end
    end
    @(posedge clk);
    #1;
    req_v[m] = 1'b0;
    if (n >= 400) chk("t3_budget", 0, 1);
  endtask

  task automatic rand_drv(input int m, input int cnt);
    int t, sel;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      sel = $urandom_range(0, 9);
      addr_v[m] = 32'($urandom_range(0, 31)) * 4;
      if (sel == 0) addr_v[m] = addr_v[m] | 32'($urandom_range(1, 3));
      else if (sel == 1)
        addr_v[m] = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      else if (sel == 2) addr_v[m] = 32'hFFFF_FFFC;
      rw_v[m] = 1'($urandom_range(0, 1));
      wd_v[m] = $urandom;
      req_v[m] = 1'b1;
      wait_gnt(m, t);
      @(posedge clk);
      #1;
      req_v[m] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, c0, t;
    addr_v[0] = '0;
    addr_v[1] = '0;
    wd_v[0] = '0;
    wd_v[1] = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'(i) * 32'h9E37_79B9;
      ref_mem[i] = 32'(i) * 32'h9E37_79B9;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // basic write then read on m0
    c0 = rw_cnt;
    txn(0, 1'b1, 32'h100, 32'hABCDEF12, rd, e, lat);
    chk("t1_wr_lat", 64'(lat), 3);
    chk("t1_rw_pulses", 64'(rw_cnt - c0), 1);
    chk("t1_rw_addr", last_rw_addr, 12'h100);
    txn(0, 1'b0, 32'h100, 32'h0, rd, e, lat);
    chk("t1_rd_lat", 64'(lat), 3);
    chk("t1_rd_data", rd, 32'hABCDEF12);
    chk("t1_rd_err", e, 0);

    // window boundaries through m1
    txn(1, 1'b1, 32'hFFC, 32'hAABBCCDD, rd, e, lat);
    txn(1, 1'b0, 32'hFFC, 32'h0, rd, e, lat);
    chk("t2_top_data", rd, 32'hAABBCCDD);
    chk("t2_top_err", e, 0);
    txn(1, 1'b1, 32'h000, 32'hDEADBEEF, rd, e, lat);
    txn(1, 1'b0, 32'h000, 32'h0, rd, e, lat);
    chk("t2_bot_data", rd, 32'hDEADBEEF);

    // both masters saturating: 4 m0 grants then one m1
    gq.delete();
    fork
      stream(0);
      stream(1);
    join
    drain();
    chk("t3_count", 64'(gq.size() >= 20), 1);
    for (int i = 0; i < 20 && i < gq.size(); i++)
      chk($sformatf("t3_gnt%0d", i), gq[i], (i % 5 == 4));

    // range and alignment errors
    c0 = rw_cnt;
    txn(0, 1'b0, 32'h0000_1000, 32'h0, rd, e, lat);
    chk("t4_rng_lat", 64'(lat), 1);
    chk("t4_rng_err", e, 1);
    chk("t4_rng_data", rd, 0);
    txn(1, 1'b1, 32'h102, 32'h12345678, rd, e, lat);
    chk("t4_aln_lat", 64'(lat), 1);
    chk("t4_aln_err", e, 1);
    chk("t4_aln_data", rd, 0);
    chk("t4_no_rw", 64'(rw_cnt - c0), 0);

    // completion timeout, then recovery
    rdy_mode = 2;
    txn(0, 1'b0, 32'h100, 32'h0, rd, e, lat);
    chk("t5_to_lat", 64'(lat), 18);
    chk("t5_to_err", e, 1);
    chk("t5_to_data", rd, 0);
    rdy_mode = 0;
    txn(0, 1'b0, 32'h100, 32'h0, rd, e, lat);
    chk("t5_ok_lat", 64'(lat), 3);
    chk("t5_ok_data", rd, 32'hABCDEF12);
    chk("t5_ok_err", e, 0);

    // reset while an access sits in WAIT
    txn(1, 1'b1, 32'h200, 32'h55555555, rd, e, lat);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    rw_v[0] = 1'b0;
    addr_v[0] = 32'h300;
    req_v[0] = 1'b1;
    wait_gnt(0, t);
    @(posedge clk);
    #1;
    req_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_rst_ctl", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
                       m0_err, m1_err, dtcm_rw}, 0);
    chk("t6_rst_bus", {dtcm_addr, dtcm_wdata}, 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    rdy_mode = 0;
    repeat (20) @(posedge clk);
    txn(1, 1'b0, 32'h200, 32'h0, rd, e, lat);
    chk("t6_lat", 64'(lat), 3);
    chk("t6_data", rd, 32'h55555555);
    chk("t6_err", e, 0);

    // randomized traffic with a jittery ready
    rdy_mode = 1;
    fork
      rand_drv(0, 40);
      rand_drv(1, 40);
    join
    drain();
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
